// File: rtl/ifmap_feeder_if.sv
// Pixel-source and IFmap-buffer signal bundle for the IFmap feeder.
// The slave modport is the feeder's view; master is the surrounding environment.
interface ifmap_feeder_if #(
  parameter int IFMAP_BUFFER_WIDTH = 10,
  parameter int DATA_WIDTH         = IFMAP_BUFFER_WIDTH - 2
);
  logic [DATA_WIDTH-1:0]         src_data;
  logic                          src_valid;
  logic                          src_ready;
  logic [IFMAP_BUFFER_WIDTH-1:0] IFmap_buffer_in;
  logic                          IFmap_buffer_write_enable;
  logic                          IFmap_buffer_full;

  modport slave (
    input  src_data, src_valid, IFmap_buffer_full,
    output src_ready, IFmap_buffer_in, IFmap_buffer_write_enable
  );

  modport master (
    output src_data, src_valid, IFmap_buffer_full,
    input  src_ready, IFmap_buffer_in, IFmap_buffer_write_enable
  );
endinterface

// File: rtl/ifmap_feeder.sv
// Tags a raw pixel stream with row start/end flags and writes it to the CNN IFmap buffer.
// One-entry hold register: accept at edge k, write at edge k+1; buffer-full stalls the source.
module ifmap_feeder #(
  parameter int IFMAP_BUFFER_WIDTH = 10,
  parameter int DATA_WIDTH         = IFMAP_BUFFER_WIDTH - 2,
  parameter int LEN_WIDTH          = 8,
  parameter int ROWS_WIDTH         = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  row_len,
  input  logic [ROWS_WIDTH-1:0] num_rows,
  ifmap_feeder_if.slave         bus,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_error
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE_ST
  } state_t;

  state_t                        state, state_nxt;
  logic [LEN_WIDTH-1:0]          len_q;
  logic [ROWS_WIDTH-1:0]         rows_q;
  logic [LEN_WIDTH-1:0]          col;
  logic [ROWS_WIDTH-1:0]         row;
  logic                          hold_valid;
  logic [IFMAP_BUFFER_WIDTH-1:0] hold_word;

  logic cfg_ok;
  logic last_col;
  logic last_row;
  logic accept;
  logic wr_en;
  logic rdy;

  assign cfg_ok   = (row_len != '0) && (num_rows != '0);
  assign last_col = (col == len_q - LEN_WIDTH'(1));
  assign last_row = (row == rows_q - ROWS_WIDTH'(1));

  // Outputs are gated by reset so an aborted frame never leaks its held word.
  always_comb begin
    rdy       = 1'b0;
    wr_en     = 1'b0;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    state_nxt = state;
    if (!reset) begin
      wr_en  = hold_valid && !bus.IFmap_buffer_full;
      rdy    = (state == STREAM) && (!hold_valid || !bus.IFmap_buffer_full);
      accept = bus.src_valid && rdy;
    end
    case (state)
      IDLE: begin
        if (start && cfg_ok) state_nxt = STREAM;
      end
      STREAM: begin
        busy = 1'b1;
        if (accept && last_col && last_row) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!hold_valid) state_nxt = DONE_ST;
      end
      DONE_ST: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.src_ready                 = rdy;
  assign bus.IFmap_buffer_write_enable = wr_en;
  assign bus.IFmap_buffer_in           = hold_word;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q      <= '0;
      rows_q     <= '0;
      col        <= '0;
      row        <= '0;
      hold_valid <= 1'b0;
      hold_word  <= '0;
      cfg_error  <= 1'b0;
    end else begin
      cfg_error <= 1'b0;
      if (state == IDLE && start) begin
        if (cfg_ok) begin
          len_q  <= row_len;
          rows_q <= num_rows;
          col    <= '0;
          row    <= '0;
        end else begin
          cfg_error <= 1'b1;
        end
      end
      // A same-cycle accept overwrites the word being written, keeping one pixel per cycle.
      if (accept) begin
        hold_word  <= {(col == '0), last_col, bus.src_data};
        hold_valid <= 1'b1;
        if (last_col) begin
          col <= '0;
          row <= row + ROWS_WIDTH'(1);
        end else begin
          col <= col + LEN_WIDTH'(1);
        end
      end else if (wr_en) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifmap_feeder.sv
// Directed bench for ifmap_feeder: tagged word order, stalls, zero-size starts, aborts.
module tb_ifmap_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] row_len;
  logic [7:0] num_rows;
  logic       busy;
  logic       done;
  logic       cfg_error;

  ifmap_feeder_if bus_if ();

  ifmap_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .row_len   (row_len),
    .num_rows  (num_rows),
    .bus       (bus_if),
    .busy      (busy),
    .done      (done),
    .cfg_error (cfg_error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [9:0] wr_q[$];
  int last_wr, done_c, done_n, busy_bad, stall_bad, cfg_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input int len, input int rows);
    @(negedge clk);
    start    = 1'b1;
    row_len  = 8'(len);
    num_rows = 8'(rows);
  endtask

  // Per-cycle driver and monitor. full is asserted for cycles full_from..full_to,
  // a stray start is pulsed at mid_start_at, stop_acc ends the run after that many accepts.
  task automatic feed(input int len, input int rows, input int base, input int full_from,
                      input int full_to, input int stop_acc, input int mid_start_at);
    int idx, npix, post;
    logic [9:0] held;
    idx = 0; npix = len * rows; post = 0; held = '0;
    wr_q.delete();
    last_wr = -1; done_c = -1; done_n = 0; busy_bad = 0; stall_bad = 0; cfg_n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start = (c == mid_start_at);
      if (c == mid_start_at) begin
        row_len  = 8'd1;
        num_rows = 8'd0;
      end
      bus_if.IFmap_buffer_full = (c >= full_from && c <= full_to);
      bus_if.src_valid         = (idx < npix);
      bus_if.src_data          = 8'(base + idx);
      #1;
      if (bus_if.src_valid && bus_if.src_ready) idx++;
      if (bus_if.IFmap_buffer_write_enable) begin
        wr_q.push_back(bus_if.IFmap_buffer_in);
        last_wr = c;
      end
      if (c == full_from) held = bus_if.IFmap_buffer_in;
      if (bus_if.IFmap_buffer_full &&
          (bus_if.IFmap_buffer_write_enable || bus_if.src_ready || bus_if.IFmap_buffer_in !== held))
        stall_bad++;
      if (done) begin
        done_n++;
        if (done_c < 0) done_c = c;
        if (busy) busy_bad++;
      end else if (done_c < 0 && !busy) begin
        busy_bad++;
      end
      if (cfg_error) cfg_n++;
      if (stop_acc > 0 && idx == stop_acc) break;
      if (done_c >= 0) begin
        post++;
        if (post > 3) break;
      end
    end
    start = 1'b0;
    bus_if.src_valid = 1'b0;
    bus_if.IFmap_buffer_full = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int len, input int rows, input int base);
    logic [9:0] e;
    chk({tag, "_count"}, wr_q.size(), len * rows);
    for (int i = 0; i < wr_q.size() && i < len * rows; i++) begin
      e[9]   = ((i % len) == 0);
      e[8]   = ((i % len) == len - 1);
      e[7:0] = 8'(base + i);
      chk($sformatf("%s_word%0d", tag, i), wr_q[i], e);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cfg"}, cfg_error, 0);
    chk({tag, "_rdy"}, bus_if.src_ready, 0);
    chk({tag, "_we"}, bus_if.IFmap_buffer_write_enable, 0);
    chk({tag, "_word"}, bus_if.IFmap_buffer_in, 0);
  endtask

  initial begin
    int bad, wcnt, dcnt;
    reset = 1'b1; start = 1'b0; row_len = '0; num_rows = '0;
    bus_if.src_valid = 1'b0; bus_if.src_data = '0; bus_if.IFmap_buffer_full = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Basic 3x2 frame, no backpressure
    do_start(3, 2);
    feed(3, 2, 8'h10, -1, -2, 0, -1);
    check_frame("basic", 3, 2, 8'h10);
    chk("basic_done_gap", 32'(done_c - last_wr), 2);
    chk("basic_done_n", done_n, 1);
    chk("basic_busy", busy_bad, 0);
    chk("basic_cfg", cfg_n, 0);

    // Same frame with the buffer full for cycles 3..6
    do_start(3, 2);
    feed(3, 2, 8'h20, 3, 6, 0, -1);
    check_frame("stall", 3, 2, 8'h20);
    chk("stall_hold", stall_bad, 0);
    chk("stall_done_n", done_n, 1);

    // Single-pixel rows: both flags on every word
    do_start(1, 4);
    feed(1, 4, 8'h0A, -1, -2, 0, -1);
    check_frame("len1", 1, 4, 8'h0A);
    chk("len1_done_n", done_n, 1);

    // Zero row length is rejected, then a valid frame runs
    @(negedge clk);
    start = 1'b1; row_len = 8'd0; num_rows = 8'd5; bus_if.src_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("zero_cfg", cfg_error, 1);
    chk("zero_busy", busy, 0);
    chk("zero_rdy", bus_if.src_ready, 0);
    @(negedge clk);
    #1;
    chk("zero_cfg_pulse", cfg_error, 0);
    chk("zero_busy2", busy, 0);
    chk("zero_rdy2", bus_if.src_ready, 0);
    bus_if.src_valid = 1'b0;
    do_start(2, 1);
    feed(2, 1, 8'h40, -1, -2, 0, -1);
    check_frame("after_zero", 2, 1, 8'h40);
    chk("after_zero_done_n", done_n, 1);

    // Reset after the second accepted pixel of a 3x3 frame
    do_start(3, 3);
    feed(3, 3, 8'h30, -1, -2, 2, -1);
    @(negedge clk);
    reset = 1'b1; bus_if.src_valid = 1'b1;
    #1 chk("abort_no_write", bus_if.IFmap_buffer_write_enable, 0);
    @(negedge clk);
    #1 chk_all_zero("abort");
    @(negedge clk);
    reset = 1'b0;
    wcnt = 0; dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (bus_if.IFmap_buffer_write_enable) wcnt++;
      if (done) dcnt++;
    end
    bus_if.src_valid = 1'b0;
    chk("abort_writes", wcnt, 0);
    chk("abort_done", dcnt, 0);
    do_start(3, 3);
    feed(3, 3, 8'h50, -1, -2, 0, -1);
    check_frame("restart", 3, 3, 8'h50);
    chk("restart_done_n", done_n, 1);

    // Stray src_valid in IDLE and stray start mid-frame are ignored
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_if.src_valid = 1'b1;
      bus_if.src_data  = 8'hEE;
      #1;
      if (bus_if.src_ready || bus_if.IFmap_buffer_write_enable) bad++;
    end
    bus_if.src_valid = 1'b0;
    chk("idle_valid", bad, 0);
    do_start(2, 2);
    feed(2, 2, 8'h60, -1, -2, 0, 2);
    check_frame("midstart", 2, 2, 8'h60);
    chk("midstart_cfg", cfg_n, 0);
    chk("midstart_done_n", done_n, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
